// File: rtl/lsu_pkg.sv
// Shared types and request-legality helpers for the load/store RMW sequencer.
// Only word-wide (32-bit) data memory is supported.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LDCAP,
    S_MERGE,
    S_WR,
    S_RESP,
    S_ERR
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_H, F3_HU: bad = offset[0];
      F3_W:        bad = (offset != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Both kinds at once is illegal regardless of funct3.
  function automatic logic illegal_req(input logic is_rd, input logic is_wr,
                                       input logic [2:0] funct3, input logic [1:0] offset);
    logic bad;
    if (is_rd && is_wr)
      bad = 1'b1;
    else if (is_rd)
      bad = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else
      bad = !(funct3 inside {F3_B, F3_H, F3_W});
    return bad || misaligned(funct3, offset);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges byte/half store data into an old word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                     input logic [1:0] off,
                                                     input logic [2:0] f3);
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] res;
    lane_b = 8'(word >> {off, 3'b000});
    lane_h = 16'(word >> {off[1], 4'b0000});
    case (f3)
      F3_B:    res = {{(DATA_W-8){lane_b[7]}}, lane_b};
      F3_BU:   res = {{(DATA_W-8){1'b0}}, lane_b};
      F3_H:    res = {{(DATA_W-16){lane_h[15]}}, lane_h};
      F3_HU:   res = {{(DATA_W-16){1'b0}}, lane_h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] wd,
                                                     input logic [1:0] off,
                                                     input logic [2:0] f3);
    logic [DATA_W-1:0] mask;
    logic [4:0]        sh;
    sh = {off, 3'b000};
    case (f3)
      F3_B:    mask = DATA_W'(8'hFF) << sh;
      F3_H:    mask = DATA_W'(16'hFFFF) << sh;
      default: mask = '1;
    endcase
    return (old_word & ~mask) | ((wd << sh) & mask);
  endfunction

  assign load_data  = load_extend(mem_rd, offset, funct3);
  assign merge_data = store_merge(mem_rd, wdata, offset, funct3);

endmodule

// File: rtl/lsu_rmw_ctrl.sv
// Load/store sequencer in front of a word-only synchronous SRAM: loads read and
// extract, SB/SH do read-modify-write, SW writes directly, bad requests error out.
module lsu_rmw_ctrl
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd
);

  state_t                  state;
  logic [DM_ADDRESS-1:0]   addr_reg;
  logic [2:0]              funct3_reg;
  logic                    is_load;
  logic [DATA_W-1:0]       wd_reg;
  logic [DATA_W-1:0]       rdata_reg;
  logic [DATA_W-1:0]       load_data;
  logic [DATA_W-1:0]       merge_data;

  // wd_reg holds raw store data until MERGE overwrites it with the merged word.
  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .mem_rd     (mem_rd),
    .wdata      (wd_reg),
    .offset     (addr_reg[1:0]),
    .funct3     (funct3_reg),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_reg   <= '0;
      funct3_reg <= '0;
      is_load    <= 1'b0;
      wd_reg     <= '0;
      rdata_reg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && (req_read || req_write)) begin
            addr_reg   <= req_addr;
            funct3_reg <= req_funct3;
            is_load    <= req_read;
            wd_reg     <= req_wdata;
            rdata_reg  <= '0;
            if (illegal_req(req_read, req_write, req_funct3, req_addr[1:0]))
              state <= S_ERR;
            else if (req_read || (req_funct3 != F3_W))
              state <= S_RD;
            else
              state <= S_WR;
          end
        end
        S_RD:    state <= is_load ? S_LDCAP : S_MERGE;
        S_LDCAP: begin
          rdata_reg <= load_data;
          state     <= S_RESP;
        end
        S_MERGE: begin
          wd_reg <= merge_data;
          state  <= S_WR;
        end
        S_WR:    state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory strobes depend on state only, so req_* never reaches mem_* combinationally.
  assign req_ready  = (state == S_IDLE);
  assign mem_re     = (state == S_RD);
  assign mem_we     = (state == S_WR);
  assign mem_a      = {addr_reg[DM_ADDRESS-1:2], 2'b00};
  assign mem_wd     = wd_reg;
  assign resp_valid = (state == S_RESP) || (state == S_ERR);
  assign resp_err   = (state == S_ERR);
  assign resp_rdata = rdata_reg;

endmodule

// File: doc/lsu_rmw_ctrl.md
Name: lsu_rmw_ctrl

Overview:
- Load/store sequencer between the EX/MEM pipeline register and `datamemory` in its SRAM (word-only) build.
- Turns LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word SRAM accesses:
  - loads: word read, then lane extract and sign/zero extension;
  - SB/SH: read-modify-write;
  - SW: direct write.
- Rejects misaligned and illegal requests with an error response, without touching memory.
- Stalls the pipeline through a valid/ready handshake.

Parameters:
- DM_ADDRESS, 9, byte-address width presented to data memory.
- DATA_W, 32, data word width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present from EX/MEM.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_read  in  1  load request (MemRead).
- req_write  in  1  store request (MemWrite).
- req_addr  in  DM_ADDRESS  byte address.
- req_funct3  in  3  access type.
- req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualified by resp_valid; misaligned, illegal funct3, or both req_read and req_write high.
- resp_rdata  out  DATA_W  extended load data, qualified by resp_valid; 0 for stores and errors.
- mem_re  out  1  to datamemory MemRead.
- mem_we  out  1  to datamemory MemWrite.
- mem_a  out  DM_ADDRESS  word-aligned address; bits [1:0] are always 0.
- mem_wd  out  DATA_W  full word to write.
- mem_rd  in  DATA_W  read data; valid the cycle after mem_re (synchronous SRAM).

Behaviour:
- Reset (reset_n low at a clock edge):
  - state goes to IDLE; all request registers clear;
  - resp_valid, resp_err, mem_re and mem_we are 0; resp_rdata, mem_a and mem_wd are 0.
  - Reset mid-operation abandons the transaction; no write is issued after the reset edge, and a half-done RMW leaves memory unmodified.
- States: IDLE, RD, LDCAP, MERGE, WR, RESP, ERR.
- mem_re/mem_we are decoded from state; mem_a/mem_wd come from registers. No combinational path from req_* to mem_*.
- IDLE:
  - req_ready=1.
  - When req_valid is high, latch addr, funct3, wdata and the read/write kind.
  - req_valid with neither req_read nor req_write is ignored and not accepted.
  - Error condition, which goes to ERR:
    - both req_read and req_write high;
    - load funct3 not in {000,001,010,100,101};
    - store funct3 not in {000,001,010};
    - halfword access with addr[0]=1;
    - word access with addr[1:0]!=0.
  - Otherwise: load or SB/SH go to RD; SW goes to WR with wd_reg set to wdata.
- RD: mem_re=1, mem_a={addr[DM_ADDRESS-1:2],2'b00}. Next state is LDCAP for a load, MERGE for a store.
- LDCAP: select lane from mem_rd, then:
  - byte k → mem_rd[8k+7:8k];
  - half h → mem_rd[16h+15:16h];
  - sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW.
  - Register the result into resp_rdata; go to RESP.
- MERGE: wd_reg = mem_rd with the target lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH); other bytes are preserved bit-exact. Go to WR.
- WR: mem_we=1, mem_wd=wd_reg, mem_a word-aligned. Go to RESP.
- RESP: resp_valid=1, resp_err=0 for one cycle; go to IDLE. The next request can be accepted on the following cycle.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0, no memory activity; go to IDLE.
- Latency from the acceptance edge to the resp_valid cycle:
  - load: 3 cycles;
  - SB/SH: 4 cycles;
  - SW: 2 cycles;
  - error: 1 cycle.
- req_ready=0 in every state except IDLE. Upstream holds req_* stable while stalled; changes to req_* during a transaction have no effect.
- mem_re and mem_we are never high in the same cycle.

Decomposition:
- lsu_pkg holds:
  - the state enum;
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - a misalign-check function.
- Sub-module lsu_lane_align (combinational), with two functions:
  - load extract/extend: mem_rd, offset, funct3 → rdata;
  - store merge: old word, wdata, offset, funct3 → merged word.

Test Plan:
- SW addr 0x010 wdata 0xDEADBEEF → one mem_we cycle with mem_a=0x010, mem_wd=0xDEADBEEF; resp_valid 2 cycles after acceptance; no mem_re.
- Word 0x010 preloaded 0xDEADBEEF; SB addr 0x012 wdata 0x000000AA → mem_re, then mem_we with mem_wd=0xDEAABEEF; SH addr 0x012 wdata 0x1234 → mem_wd=0x1234BEEF.
- Word 0x020 = 0x80F17F01:
  - LB @0x023 → 0xFFFFFF80;
  - LBU @0x023 → 0x00000080;
  - LH @0x022 → 0xFFFF80F1;
  - LHU @0x020 → 0x00007F01;
  - LW @0x020 → 0x80F17F01;
  - each response 3 cycles after acceptance.
- Errors, each giving resp_err=1 one cycle after acceptance with no mem_re/mem_we:
  - LW @0x021;
  - SH @0x013;
  - load funct3=011;
  - store funct3=100;
  - req_read and req_write both high.
- Back-to-back SB then LW with req_valid held high → req_ready low until RESP has passed; LW returns the merged word; no request is lost or duplicated.
- reset_n low during MERGE of an SB → no mem_we after the reset edge; memory word unchanged; req_ready=1 and all outputs 0 in the cycle after reset releases.
